// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package  : game_pkg
// Purpose  : Shared types, constants and hand arithmetic for the BlackJack turn controller.
// Revision : 1.0
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_HIT = 2'd1, CMD_STAND = 2'd2} command_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0, RES_PLAYER_WIN = 2'd1, RES_DEALER_WIN = 2'd2, RES_PUSH = 2'd3
  } result_t;

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
    PLAYER_TURN, PLAYER_HIT, DEALER_TURN, DEALER_HIT, RESULT
  } state_t;

  localparam logic [4:0] BUST_LIMIT = 5'd21;
  localparam logic [3:0] ACE_VALUE  = 4'd11;

  typedef struct packed {
    logic [4:0] total;
    logic [2:0] aces;   // aces still counted as 11
  } hand_t;

  function automatic hand_t add_card(hand_t h, logic [3:0] value);
    hand_t r;
    r.total = h.total + {1'b0, value};
    r.aces  = h.aces + {2'b00, (value == ACE_VALUE)};
    if (r.total > BUST_LIMIT && r.aces != 3'd0) begin
      r.total = r.total - 5'd10;
      r.aces  = r.aces - 3'd1;
    end
    return r;
  endfunction

  function automatic result_t decide(logic [4:0] player, logic [4:0] dealer);
    if (player > BUST_LIMIT)      return RES_DEALER_WIN;
    else if (dealer > BUST_LIMIT) return RES_PLAYER_WIN;
    else if (player > dealer)     return RES_PLAYER_WIN;
    else if (dealer > player)     return RES_DEALER_WIN;
    else                          return RES_PUSH;
  endfunction

  function automatic logic needs_card(state_t s);
    return (s == DEAL_P1) || (s == DEAL_D1) || (s == DEAL_P2) || (s == DEAL_D2) ||
           (s == PLAYER_HIT) || (s == DEALER_HIT);
  endfunction

  function automatic logic dealer_card(state_t s);
    return (s == DEAL_D1) || (s == DEAL_D2) || (s == DEALER_HIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/turn_controller_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronises one active-low key, debounces it (TURN_CTRL_DEBOUNCE_EN) and emits a press pulse.
// Revision : 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  logic sync1_q, sync2_q, level_q, level_d, press_q, press_d;

`ifdef TURN_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] cnt_q, cnt_d;

  // level only follows the synchronised key after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign level_d = sync2_q;
`endif

  assign press_d = level_d & ~level_q;
  assign o_press = press_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= ~i_key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : turn_controller
// Purpose  : BlackJack turn sequencer: key presses, deal/player/dealer order, card req/ack, totals, result.
//            Key debouncing enabled by `TURN_CTRL_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module turn_controller
  import game_pkg::*;
#(
  parameter int DEALER_STAND    = 17,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_KEY,
  input  logic       i_cardAck,
  input  logic [3:0] i_cardValue,
  output logic       o_cardReq,
  output logic       o_cardDest,
  output logic       o_turnIndicator,
  output command_t   o_command,
  output logic [4:0] o_playerTotal,
  output logic [4:0] o_dealerTotal,
  output result_t    o_result,
  output logic       o_gameOver
);

  localparam logic [4:0] STAND_LIMIT = 5'(DEALER_STAND);

  logic [2:0] press;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_KEY[k]),
      .o_press (press[k])
    );
  end

  state_t   state_q, state_d;
  hand_t    player_q, player_d, dealer_q, dealer_d, player_add, dealer_add;
  logic     req_q, req_d, dest_q, dest_d, turn_q, turn_d, over_q, over_d, ack;
  command_t cmd_q, cmd_d;
  result_t  result_q, result_d;

  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    dealer_d   = dealer_q;
    result_d   = result_q;
    cmd_d      = CMD_NONE;
    ack        = req_q & i_cardAck;
    player_add = add_card(player_q, i_cardValue);
    dealer_add = add_card(dealer_q, i_cardValue);

    case (state_q)
      IDLE, RESULT: if (press[2]) begin
        state_d  = DEAL_P1;
        player_d = '0;
        dealer_d = '0;
        result_d = RES_NONE;
      end
      DEAL_P1: if (ack) begin player_d = player_add; state_d = DEAL_D1; end
      DEAL_D1: if (ack) begin dealer_d = dealer_add; state_d = DEAL_P2; end
      DEAL_P2: if (ack) begin player_d = player_add; state_d = DEAL_D2; end
      DEAL_D2: if (ack) begin
        dealer_d = dealer_add;
        state_d  = (player_q.total == BUST_LIMIT) ? DEALER_TURN : PLAYER_TURN;
      end
      PLAYER_TURN: begin
        if (press[1]) begin
          cmd_d   = CMD_STAND;
          state_d = DEALER_TURN;
        end else if (press[0]) begin
          cmd_d   = CMD_HIT;
          state_d = PLAYER_HIT;
        end
      end
      PLAYER_HIT: if (ack) begin
        player_d = player_add;
        if (player_add.total > BUST_LIMIT) begin
          state_d  = RESULT;
          result_d = decide(player_add.total, dealer_q.total);
        end else if (player_add.total == BUST_LIMIT) begin
          state_d = DEALER_TURN;
        end else begin
          state_d = PLAYER_TURN;
        end
      end
      DEALER_TURN: begin
        if (dealer_q.total < STAND_LIMIT) begin
          state_d = DEALER_HIT;
        end else begin
          state_d  = RESULT;
          result_d = decide(player_q.total, dealer_q.total);
        end
      end
      DEALER_HIT: if (ack) begin dealer_d = dealer_add; state_d = DEALER_TURN; end
      default: state_d = IDLE;
    endcase

    // request rises the cycle after entering a card state and drops right after the ack
    req_d  = needs_card(state_q) & ~ack;
    dest_d = dealer_card(state_q);
    turn_d = (state_d == PLAYER_TURN);
    over_d = (state_d == RESULT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      player_q <= '0;
      dealer_q <= '0;
      req_q    <= 1'b0;
      dest_q   <= 1'b0;
      turn_q   <= 1'b0;
      over_q   <= 1'b0;
      cmd_q    <= CMD_NONE;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      dealer_q <= dealer_d;
      req_q    <= req_d;
      dest_q   <= dest_d;
      turn_q   <= turn_d;
      over_q   <= over_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
    end
  end

  assign o_cardReq       = req_q;
  assign o_cardDest      = dest_q;
  assign o_turnIndicator = turn_q;
  assign o_command       = cmd_q;
  assign o_playerTotal   = player_q.total;
  assign o_dealerTotal   = dealer_q.total;
  assign o_result        = result_q;
  assign o_gameOver      = over_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_controller
// Purpose  : Directed self-checking bench for turn_controller.
// Revision : 1.0
// ============================================================================
module tb_turn_controller;

  logic       clk, rst;
  logic [2:0] i_KEY;
  logic       i_cardAck;
  logic [3:0] i_cardValue;
  logic       o_cardReq, o_cardDest, o_turnIndicator, o_gameOver;
  logic [1:0] o_command, o_result;
  logic [4:0] o_playerTotal, o_dealerTotal;

  int n_checks, n_errors;
  int hit_cnt, stand_cnt, req_cycles;

  turn_controller #(.DEALER_STAND(17), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_KEY           (i_KEY),
    .i_cardAck       (i_cardAck),
    .i_cardValue     (i_cardValue),
    .o_cardReq       (o_cardReq),
    .o_cardDest      (o_cardDest),
    .o_turnIndicator (o_turnIndicator),
    .o_command       (o_command),
    .o_playerTotal   (o_playerTotal),
    .o_dealerTotal   (o_dealerTotal),
    .o_result        (o_result),
    .o_gameOver      (o_gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_command == 2'd1) hit_cnt++;
    if (o_command == 2'd2) stand_cnt++;
    if (o_cardReq) req_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // keys are active-low; mask bit set = key held
  task automatic press(input logic [2:0] mask);
    i_KEY = ~mask;
    repeat (8) @(negedge clk);
    i_KEY = 3'b111;
    repeat (10) @(negedge clk);
  endtask

  task automatic serve(input logic [3:0] value, input logic dest);
    int n = 0;
    while (!o_cardReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_cardReq) begin
      check("req_timeout", 32'(o_cardReq), 32'd1);
    end else begin
      check("card_dest", 32'(o_cardDest), 32'(dest));
      i_cardAck   = 1'b1;
      i_cardValue = value;
      @(negedge clk);
      i_cardAck = 1'b0;
      check("req_drop", 32'(o_cardReq), 32'd0);
    end
  endtask

  int s0, h0, r0;

  initial begin
    n_checks = 0; n_errors = 0; hit_cnt = 0; stand_cnt = 0; req_cycles = 0;
    rst = 1'b1; i_KEY = 3'b111; i_cardAck = 1'b0; i_cardValue = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(o_cardReq), 0);
    check("rst_turn", 32'(o_turnIndicator), 0);
    check("rst_cmd", 32'(o_command), 0);
    check("rst_ptot", 32'(o_playerTotal), 0);
    check("rst_dtot", 32'(o_dealerTotal), 0);
    check("rst_result", 32'(o_result), 0);
    check("rst_over", 32'(o_gameOver), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef TURN_CTRL_DEBOUNCE_EN
    i_KEY = 3'b011;
    repeat (3) @(negedge clk);
    i_KEY = 3'b111;
    repeat (15) @(negedge clk);
    check("glitch_no_deal", 32'(req_cycles), 0);
`endif

    // Round 1: 10,7,9,8 then stand, dealer draws 5
    press(3'b100);
    serve(4'd10, 1'b0); serve(4'd7, 1'b1); serve(4'd9, 1'b0); serve(4'd8, 1'b1);
    repeat (3) @(negedge clk);
    check("r1_ptot", 32'(o_playerTotal), 19);
    check("r1_dtot", 32'(o_dealerTotal), 15);
    check("r1_turn", 32'(o_turnIndicator), 1);
    check("r1_req_idle", 32'(o_cardReq), 0);
    i_cardAck = 1'b1; i_cardValue = 4'd9;
    @(negedge clk);
    i_cardAck = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_ptot", 32'(o_playerTotal), 19);
    check("stray_ack_dtot", 32'(o_dealerTotal), 15);
    s0 = stand_cnt;
    press(3'b010);
    check("r1_stand_pulse", 32'(stand_cnt - s0), 1);
    serve(4'd5, 1'b1);
    repeat (3) @(negedge clk);
    check("r1_dtot_final", 32'(o_dealerTotal), 20);
    check("r1_result", 32'(o_result), 2);
    check("r1_over", 32'(o_gameOver), 1);
    check("r1_turn_off", 32'(o_turnIndicator), 0);

    // Round 2: soft aces, then bust
    press(3'b100);
    check("r2_ptot_cleared", 32'(o_playerTotal), 0);
    check("r2_result_cleared", 32'(o_result), 0);
    serve(4'd11, 1'b0); serve(4'd5, 1'b1); serve(4'd11, 1'b0); serve(4'd6, 1'b1);
    repeat (3) @(negedge clk);
    check("r2_two_aces", 32'(o_playerTotal), 12);
    check("r2_dtot", 32'(o_dealerTotal), 11);
    h0 = hit_cnt;
    press(3'b001);
    check("r2_hit_pulse", 32'(hit_cnt - h0), 1);
    serve(4'd10, 1'b0);
    repeat (3) @(negedge clk);
    check("r2_ace_hardened", 32'(o_playerTotal), 12);
    check("r2_turn_back", 32'(o_turnIndicator), 1);
    press(3'b001);
    serve(4'd10, 1'b0);
    repeat (3) @(negedge clk);
    check("r2_bust_ptot", 32'(o_playerTotal), 22);
    check("r2_bust_result", 32'(o_result), 2);
    check("r2_bust_over", 32'(o_gameOver), 1);

    // Round 3: hit and stand together, dealer stands on exactly 17
    press(3'b100);
    serve(4'd10, 1'b0); serve(4'd10, 1'b1); serve(4'd10, 1'b0); serve(4'd7, 1'b1);
    repeat (3) @(negedge clk);
    s0 = stand_cnt; h0 = hit_cnt; r0 = req_cycles;
    press(3'b011);
    check("r3_stand_wins", 32'(stand_cnt - s0), 1);
    check("r3_no_hit", 32'(hit_cnt - h0), 0);
    check("r3_no_request", 32'(req_cycles - r0), 0);
    check("r3_result", 32'(o_result), 1);
    check("r3_dtot", 32'(o_dealerTotal), 17);

    // Round 4: player 21 auto-stands, dealer 16 draws 5 -> push
    press(3'b100);
    h0 = hit_cnt; s0 = stand_cnt;
    serve(4'd11, 1'b0); serve(4'd10, 1'b1); serve(4'd10, 1'b0); serve(4'd6, 1'b1);
    serve(4'd5, 1'b1);
    repeat (3) @(negedge clk);
    check("r4_ptot", 32'(o_playerTotal), 21);
    check("r4_dtot", 32'(o_dealerTotal), 21);
    check("r4_push", 32'(o_result), 3);
    check("r4_no_cmd", 32'((hit_cnt - h0) + (stand_cnt - s0)), 0);

    // Reset in the middle of a handshake, then a late ack
    press(3'b100);
    serve(4'd4, 1'b0);
    begin
      int n = 0;
      while (!o_cardReq && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_req_seen", 32'(o_cardReq), 1);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_req_drop", 32'(o_cardReq), 0);
    @(negedge clk);
    rst = 1'b0;
    i_cardAck = 1'b1; i_cardValue = 4'd10;
    @(negedge clk);
    i_cardAck = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_ptot", 32'(o_playerTotal), 0);
    check("late_ack_dtot", 32'(o_dealerTotal), 0);
    check("late_ack_req", 32'(o_cardReq), 0);
    check("late_ack_over", 32'(o_gameOver), 0);
    check("late_ack_turn", 32'(o_turnIndicator), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
